// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the fetch-stage controller: the fetch FSM state
// encoding and the default address width / reset vector.
// -----------------------------------------------------------------------------
package pc_pkg;

  localparam int unsigned        XLEN_DEF         = 32;
  localparam logic [XLEN_DEF-1:0] RESET_VECTOR_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    HOLD   = 3'd3,
    HALTED = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
// Fetch-stage controller. Owns the program counter, issues one outstanding
// instruction-memory request at a time, holds the returned instruction for
// decode, and applies branch redirects and halt requests.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   imem_req_valid/ready  request handshake, imem_req_addr = pc
//   imem_rsp_valid/data   response (only honoured while waiting for one)
//   inst_valid/ready      decode handshake, inst_data/inst_pc held instruction
//   redirect_valid/target single-cycle branch redirect to an absolute pc
//   halt / halted         level halt request / FSM parked in HALTED
// -----------------------------------------------------------------------------
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int unsigned     PC_STEP      = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt,
  output logic            halted
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_drop;
  logic [XLEN-1:0] r_inst_data;
  logic [XLEN-1:0] r_inst_pc;

  // State to enter once the current transaction finishes: halt parks the FSM.
  fetch_state_e    w_after_txn;
  assign w_after_txn = halt ? HALTED : REQ;

  // Fetch FSM, PC register and instruction holding registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_VECTOR;
      r_inflight_pc <= {XLEN{1'b0}};
      r_drop        <= 1'b0;
      r_inst_data   <= {XLEN{1'b0}};
      r_inst_pc     <= {XLEN{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= halt ? HALTED : REQ;
        end
        REQ: begin
          if (imem_req_ready) begin
            r_inflight_pc <= r_pc;
            r_pc          <= r_pc + XLEN'(PC_STEP);
            r_state       <= WAIT;
            // Request already accepted for the old path: its response is stale.
            if (redirect_valid) r_drop <= 1'b1;
          end else if (halt) begin
            r_state <= HALTED;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            // A redirect coinciding with the response also makes it stale.
            if (r_drop || redirect_valid) begin
              r_drop  <= 1'b0;
              r_state <= w_after_txn;
            end else begin
              r_inst_data <= imem_rsp_data;
              r_inst_pc   <= r_inflight_pc;
              r_state     <= HOLD;
            end
          end else if (redirect_valid) begin
            r_drop <= 1'b1;
          end
        end
        HOLD: begin
          // Redirect discards the held instruction just like a consume does.
          if (inst_ready || redirect_valid) r_state <= w_after_txn;
        end
        HALTED: begin
          if (!halt) r_state <= REQ;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
      // Redirect wins over the sequential increment in every state.
      if (redirect_valid) r_pc <= redirect_target;
    end
  end

  assign imem_req_valid = (r_state == REQ);
  assign imem_req_addr  = r_pc;
  assign inst_valid     = (r_state == HOLD);
  assign inst_data      = r_inst_data;
  assign inst_pc        = r_inst_pc;
  assign halted         = (r_state == HALTED);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Directed testbench for pc_fetch_ctrl: sequential fetch, request stall,
// redirect drop, decode stall, halt, address wrap and reset mid-fetch.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  pc_fetch_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check request-side outputs.
  task automatic chk_req(input string name, input logic exp_v, input logic [31:0] exp_a);
    checks++;
    if (imem_req_valid !== exp_v) begin
      failures++;
      $display("FAIL %s req_valid got=%b exp=%b", name, imem_req_valid, exp_v);
    end
    checks++;
    if (imem_req_addr !== exp_a) begin
      failures++;
      $display("FAIL %s req_addr got=%h exp=%h", name, imem_req_addr, exp_a);
    end
  endtask

  // One fetch from REQ state with ready=1, 1-cycle response, decode ready.
  task automatic fetch_one(input string name, input logic [31:0] addr, input logic [31:0] data);
    chk_req({name, "_req"}, 1'b1, addr);
    imem_req_ready = 1'b1;
    tick();                                   // request handshake -> WAIT
    chk_req({name, "_wait"}, 1'b0, addr + 32'd4);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();                                   // response -> HOLD
    imem_rsp_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_data !== data || inst_pc !== addr) begin
      failures++;
      $display("FAIL %s_hold v=%b data=%h pc=%h exp v=1 data=%h pc=%h",
               name, inst_valid, inst_data, inst_pc, data, addr);
    end
    inst_ready = 1'b1;
    tick();                                   // decode handshake -> REQ
  endtask

  task automatic test_reset();
    reset = 1'b0;
    imem_rsp_valid = 1'b1;                    // noise during reset
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    tick();
    imem_rsp_valid = 1'b0;
    chk_req("reset", 1'b0, 32'h0000_0000);
    checks++;
    if (inst_valid !== 1'b0 || halted !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_outs v=%b halted=%b data=%h pc=%h exp 0", inst_valid, halted, inst_data, inst_pc);
    end
  endtask

  task automatic test_sequential();
    reset = 1'b1;
    tick();                                   // first edge with reset high
    fetch_one("seq0", 32'h0000_0000, 32'h1111_0000);
    fetch_one("seq1", 32'h0000_0004, 32'h1111_0004);
    chk_req("seq2_req", 1'b1, 32'h0000_0008);
  endtask

  task automatic test_req_stall();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_req("req_stall", 1'b1, 32'h0000_0008);
    end
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b1;
    tick();                                   // handshake for 0x8 -> WAIT
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0100;
    tick();                                   // redirect while waiting
    redirect_valid = 1'b0;
    chk_req("redir_wait", 1'b0, 32'h0000_0100);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0008;
    tick();                                   // stale response dropped
    imem_rsp_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_drop inst_valid got=%b exp=0", inst_valid);
    end
    chk_req("redir_req", 1'b1, 32'h0000_0100);
    fetch_one("redir0", 32'h0000_0100, 32'h2222_0100);
    chk_req("redir1_req", 1'b1, 32'h0000_0104);
  endtask

  task automatic test_hold_stall();
    imem_req_ready = 1'b1;
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h3333_0104;
    inst_ready     = 1'b0;
    tick();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_data !== 32'h3333_0104 || inst_pc !== 32'h0000_0104 ||
          imem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL hold_stall v=%b data=%h pc=%h reqv=%b exp 1/33330104/00000104/0",
                 inst_valid, inst_data, inst_pc, imem_req_valid);
      end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    chk_req("hold_release", 1'b1, 32'h0000_0108);
  endtask

  task automatic test_halt();
    imem_req_ready = 1'b1;
    tick();                                   // handshake 0x108 -> WAIT
    halt           = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h4444_0108;
    tick();
    imem_rsp_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_data !== 32'h4444_0108 || inst_pc !== 32'h0000_0108 || halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_deliver v=%b data=%h pc=%h halted=%b", inst_valid, inst_data, inst_pc, halted);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (halted !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        failures++;
        $display("FAIL halt_parked halted=%b reqv=%b instv=%b exp 1/0/0", halted, imem_req_valid, inst_valid);
      end
    end
    halt = 1'b0;
    tick();
    chk_req("halt_resume", 1'b1, 32'h0000_010C);
    checks++;
    if (halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_resume_halted got=%b exp=0", halted);
    end
  endtask

  task automatic test_wrap();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();                                   // redirect in REQ without handshake
    redirect_valid = 1'b0;
    fetch_one("wrap", 32'hFFFF_FFFC, 32'h5555_FFFC);
    chk_req("wrap_next", 1'b1, 32'h0000_0000);
  endtask

  task automatic test_reset_mid_wait();
    imem_req_ready = 1'b1;
    tick();                                   // handshake 0x0 -> WAIT
    reset = 1'b0;
    tick();
    chk_req("rst_mid", 1'b0, 32'h0000_0000);
    checks++;
    if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_inst v=%b data=%h pc=%h exp 0", inst_valid, inst_data, inst_pc);
    end
    reset          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0000;
    tick();                                   // stale response after reset
    imem_rsp_valid = 1'b0;
    chk_req("rst_restart", 1'b1, 32'h0000_0000);
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_stale inst_valid got=%b exp=0", inst_valid);
    end
    fetch_one("rst_fetch", 32'h0000_0000, 32'h6666_0000);
    chk_req("rst_next", 1'b1, 32'h0000_0004);
  endtask

  initial begin
    reset           = 1'b0;
    imem_req_ready  = 1'b1;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'h0;
    inst_ready      = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    halt            = 1'b0;

    test_reset();
    test_sequential();
    test_req_stall();
    test_redirect_wait();
    test_hold_stall();
    test_halt();
    test_wrap();
    test_reset_mid_wait();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
